// File: rtl/ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ccff_bitstream_loader
//  Description : Programming-side driver for the configuration-chain head.
//                Flushes the chain, probes its length through ccff_tail,
//                then serialises parallel bitstream words LSB-first into
//                ccff_head. IO isolation is released only after a complete,
//                length-checked load.
//  Revision    : 1.0 - initial release
// ============================================================================
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              IO_ISOL_N,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Counter must reach CHAIN_LEN (probe decision value) with headroom.
    localparam int CNT_W  = $clog2(CHAIN_LEN + 2);
    localparam int BCNT_W = $clog2(WORD_W + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FLUSH = 3'd1;
    localparam logic [2:0] S_PROBE = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] c_bits_one = CNT_W'(1);

    logic [2:0]        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic [CNT_W-1:0]  r_bits_left, w_bits_left;
    logic [WORD_W-1:0] r_buf, w_buf;
    logic [BCNT_W-1:0] r_buf_cnt, w_buf_cnt;
    logic              r_head, w_head;
    logic              r_shift_en, w_shift_en;
    logic              r_bs_ready, w_bs_ready;
    logic              r_io_isol_n, w_io_isol_n;
    logic              r_busy, w_busy;
    logic              r_done, w_done;
    logic              r_error, w_error;
    logic              w_last_word;

    // The word being accepted is the final one when it covers all remaining bits.
    assign w_last_word = (32'(r_bits_left) <= WORD_W);

    // State, counters and registered outputs.
    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bits_left <= '0;
            r_buf       <= '0;
            r_buf_cnt   <= '0;
            r_head      <= 1'b0;
            r_shift_en  <= 1'b0;
            r_bs_ready  <= 1'b0;
            r_io_isol_n <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt;
            r_bits_left <= w_bits_left;
            r_buf       <= w_buf;
            r_buf_cnt   <= w_buf_cnt;
            r_head      <= w_head;
            r_shift_en  <= w_shift_en;
            r_bs_ready  <= w_bs_ready;
            r_io_isol_n <= w_io_isol_n;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_error     <= w_error;
        end
    end

    // Next-state decision; the probe compares ccff_tail against shifts completed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (r_cnt == c_cnt_last) w_state_nxt = S_PROBE;
            end
            S_PROBE: begin
                if (ccff_tail)
                    w_state_nxt = (r_cnt == c_cnt_full) ? S_LOAD : S_ERROR;
                else if (r_cnt == c_cnt_full)
                    w_state_nxt = S_ERROR;
            end
            S_LOAD: begin
                if (r_shift_en && (r_buf_cnt == '0) && (r_bits_left == c_bits_one))
                    w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the datapath and of every registered output.
    always_comb begin
        w_cnt       = r_cnt;
        w_bits_left = r_bits_left;
        w_buf       = r_buf;
        w_buf_cnt   = r_buf_cnt;
        w_head      = 1'b0;
        w_shift_en  = 1'b0;
        w_bs_ready  = 1'b0;
        w_busy      = (w_state_nxt == S_FLUSH) || (w_state_nxt == S_PROBE) ||
                      (w_state_nxt == S_LOAD);
        w_done      = (w_state_nxt == S_DONE);
        w_error     = (w_state_nxt == S_ERROR);
        w_io_isol_n = (w_state_nxt == S_DONE);
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    w_cnt      = '0;
                    w_shift_en = 1'b1;
                end
            end
            S_FLUSH: begin
                w_shift_en = 1'b1;
                if (r_cnt == c_cnt_last) begin
                    // First probe shift carries the marker bit.
                    w_cnt  = '0;
                    w_head = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_PROBE: begin
                if (w_state_nxt == S_PROBE) begin
                    w_cnt      = r_cnt + 1'b1;
                    w_shift_en = 1'b1;
                end else if (w_state_nxt == S_LOAD) begin
                    w_bits_left = c_cnt_full;
                    w_buf_cnt   = '0;
                    w_bs_ready  = 1'b1;
                end
            end
            S_LOAD: begin
                if (r_shift_en) begin
                    w_bits_left = r_bits_left - 1'b1;
                    if (r_buf_cnt != '0) begin
                        w_head     = r_buf[0];
                        w_buf      = r_buf >> 1;
                        w_buf_cnt  = r_buf_cnt - 1'b1;
                        w_shift_en = 1'b1;
                    end else if (w_state_nxt == S_LOAD) begin
                        // Buffer drained: one bubble cycle requesting the next word.
                        w_bs_ready = 1'b1;
                    end
                end else if (r_bs_ready) begin
                    if (bs_valid) begin
                        w_head     = bs_data[0];
                        w_buf      = bs_data >> 1;
                        w_buf_cnt  = w_last_word ? BCNT_W'(r_bits_left - 1'b1)
                                                 : BCNT_W'(WORD_W - 1);
                        w_shift_en = 1'b1;
                    end else begin
                        w_bs_ready = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bs_ready      = r_bs_ready;
    assign ccff_head     = r_head;
    assign ccff_shift_en = r_shift_en;
    assign IO_ISOL_N     = r_io_isol_n;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ccff_bitstream_loader
//  Description : Directed self-checking bench for ccff_bitstream_loader with
//                behavioural configuration-chain models of selectable length.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ccff_bitstream_loader;

    logic       clk;
    logic       rst_n;
    logic [1:0] start, bs_valid, bs_ready, head, shift_en, tail;
    logic [1:0] isol_n, busy, done, err;
    logic [7:0] bs_data [2];
    logic       mon_clr;

    logic [31:0] chain [2];
    int          len [2];
    logic [7:0]  words [2][3];
    int          nwords [2];
    bit          gaps [2];
    int          acc [2], total [2], load_sh [2], ready_cyc [2], overlap [2];
    bit          seen_ready [2];
    int          n_checks, n_fail, cyc;

    ccff_bitstream_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut (
        .prog_clk(clk), .prog_reset_n(rst_n), .start(start[0]),
        .bs_data(bs_data[0]), .bs_valid(bs_valid[0]), .bs_ready(bs_ready[0]),
        .ccff_head(head[0]), .ccff_shift_en(shift_en[0]), .ccff_tail(tail[0]),
        .IO_ISOL_N(isol_n[0]), .busy(busy[0]), .done(done[0]), .error(err[0])
    );

    ccff_bitstream_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut20 (
        .prog_clk(clk), .prog_reset_n(rst_n), .start(start[1]),
        .bs_data(bs_data[1]), .bs_valid(bs_valid[1]), .bs_ready(bs_ready[1]),
        .ccff_head(head[1]), .ccff_shift_en(shift_en[1]), .ccff_tail(tail[1]),
        .IO_ISOL_N(isol_n[1]), .busy(busy[1]), .done(done[1]), .error(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chain tail taps the flop selected by the modelled chain length.
    always_comb begin
        for (int d = 0; d < 2; d++) tail[d] = chain[d][len[d]-1];
    end

    // Chain models and handshake/shift monitors.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (shift_en[d]) chain[d] <= {chain[d][30:0], head[d]};
            if (mon_clr) begin
                total[d] <= 0; load_sh[d] <= 0; ready_cyc[d] <= 0;
                overlap[d] <= 0; acc[d] <= 0; seen_ready[d] <= 1'b0;
            end else begin
                if (shift_en[d]) begin
                    total[d] <= total[d] + 1;
                    if (seen_ready[d]) load_sh[d] <= load_sh[d] + 1;
                end
                if (bs_ready[d]) begin
                    seen_ready[d] <= 1'b1;
                    ready_cyc[d]  <= ready_cyc[d] + 1;
                    if (bs_valid[d]) acc[d] <= acc[d] + 1;
                end
                if (bs_ready[d] && shift_en[d]) overlap[d] <= overlap[d] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] outs(input int d);
        return {bs_ready[d], head[d], shift_en[d], isol_n[d], busy[d], done[d], err[d]};
    endfunction

    task automatic drive(input int d);
        if (acc[d] < nwords[d]) begin
            bs_data[d]  = words[d][acc[d]];
            bs_valid[d] = gaps[d] ? ($urandom_range(0, 2) != 0) : 1'b1;
        end else begin
            bs_valid[d] = 1'b0;
        end
    endtask

    task automatic tick(input int d);
        @(negedge clk);
        start = '0;
        drive(d);
    endtask

    task automatic begin_seq(input int d, input int n, input bit g,
                             input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
        @(negedge clk);
        mon_clr     = 1'b1;
        nwords[d]   = n;
        gaps[d]     = g;
        words[d][0] = w0; words[d][1] = w1; words[d][2] = w2;
        bs_valid[d] = 1'b0;
        @(negedge clk);
        mon_clr  = 1'b0;
        start[d] = 1'b1;
        drive(d);
    endtask

    task automatic wait_end(input string tag, input int d, input int budget, output int c);
        c = 0;
        do begin
            tick(d);
            c++;
        end while (!(done[d] || err[d]) && c < budget);
        if (!(done[d] || err[d])) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; start = '0; bs_valid = '0; mon_clr = 1'b1;
        bs_data[0] = '0; bs_data[1] = '0;
        len[0] = 16; len[1] = 20;
        nwords[0] = 0; nwords[1] = 0; gaps[0] = 1'b0; gaps[1] = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs16", 32'(outs(0)), 32'd0);
        check("reset_outs20", 32'(outs(1)), 32'd0);
        rst_n = 1'b1;

        // Nominal 16-bit chain, words always valid.
        begin_seq(0, 2, 1'b0, 8'hA5, 8'h3C, 8'h00);
        tick(0);
        check("nom_running", 32'({busy[0], isol_n[0], shift_en[0], head[0]}), 32'b1010);
        wait_end("nom", 0, 200, cyc);
        check("nom_latency", 32'(cyc), 32'd51);
        check("nom_outs", 32'(outs(0)), 32'b0001010);
        check("nom_chain", chain[0] & 32'hFFFF, 32'hA53C);
        check("nom_total_shifts", 32'(total[0]), 32'd49);
        check("nom_load_shifts", 32'(load_sh[0]), 32'd16);
        check("nom_ready_cycles", 32'(ready_cyc[0]), 32'd2);
        check("nom_ready_shift_overlap", 32'(overlap[0]), 32'd0);

        // Asymmetric words expose bit ordering.
        begin_seq(0, 2, 1'b0, 8'h12, 8'h34, 8'h00);
        wait_end("order", 0, 200, cyc);
        check("order_outs", 32'(outs(0)), 32'b0001010);
        check("order_chain", chain[0] & 32'hFFFF, 32'h482C);

        // Short chain: tail rises at cnt=15.
        len[0] = 15;
        begin_seq(0, 2, 1'b0, 8'hA5, 8'h3C, 8'h00);
        wait_end("short", 0, 200, cyc);
        check("short_outs", 32'(outs(0)), 32'b0000001);
        check("short_total_shifts", 32'(total[0]), 32'd32);
        check("short_ready_cycles", 32'(ready_cyc[0]), 32'd0);

        // Long chain: no tail by cnt=16.
        len[0] = 17;
        begin_seq(0, 2, 1'b0, 8'hA5, 8'h3C, 8'h00);
        wait_end("long", 0, 200, cyc);
        check("long_outs", 32'(outs(0)), 32'b0000001);
        check("long_total_shifts", 32'(total[0]), 32'd33);
        check("long_ready_cycles", 32'(ready_cyc[0]), 32'd0);

        // Chain fixed, rerun from ERROR.
        len[0] = 16;
        begin_seq(0, 2, 1'b0, 8'hA5, 8'h3C, 8'h00);
        wait_end("fixed", 0, 200, cyc);
        check("fixed_outs", 32'(outs(0)), 32'b0001010);
        check("fixed_chain", chain[0] & 32'hFFFF, 32'hA53C);

        // 20-bit chain, partial final word, random valid gaps.
        begin_seq(1, 3, 1'b1, 8'hFF, 8'h00, 8'hFF);
        wait_end("c20", 1, 600, cyc);
        check("c20_outs", 32'(outs(1)), 32'b0001010);
        check("c20_chain", chain[1] & 32'hFFFFF, 32'hFF00F);
        check("c20_load_shifts", 32'(load_sh[1]), 32'd20);
        check("c20_total_shifts", 32'(total[1]), 32'd61);
        check("c20_words", 32'(acc[1]), 32'd3);

        // Reset pulse in the middle of LOAD.
        begin_seq(0, 2, 1'b0, 8'h12, 8'h34, 8'h00);
        repeat (40) tick(0);
        check("midrst_in_load", 32'({busy[0], seen_ready[0]}), 32'b11);
        rst_n = 1'b0;
        tick(0);
        rst_n = 1'b1;
        check("midrst_outs", 32'(outs(0)), 32'd0);
        begin_seq(0, 2, 1'b0, 8'h12, 8'h34, 8'h00);
        wait_end("after_rst", 0, 200, cyc);
        check("after_rst_outs", 32'(outs(0)), 32'b0001010);
        check("after_rst_chain", chain[0] & 32'hFFFF, 32'h482C);
        check("after_rst_total", 32'(total[0]), 32'd49);

        // start pulses during FLUSH and LOAD are ignored.
        begin_seq(0, 2, 1'b0, 8'hA5, 8'h3C, 8'h00);
        repeat (5) tick(0);
        start[0] = 1'b1;
        repeat (36) tick(0);
        start[0] = 1'b1;
        wait_end("ign", 0, 200, cyc);
        check("ign_latency", 32'(cyc), 32'd11);
        check("ign_outs", 32'(outs(0)), 32'b0001010);
        check("ign_total_shifts", 32'(total[0]), 32'd49);
        check("ign_chain", chain[0] & 32'hFFFF, 32'hA53C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Programming-side driver for the configuration-chain head (ccff_head) of the tile chain, IO tiles included.
- Receives the fabric bitstream as parallel words over a valid/ready stream and first probes the chain length through ccff_tail.
- Serialises the bitstream into the chain, gating the chain clock through an external clock-gate enable.
- Holds IO isolation (IO_ISOL_N low) until the full bitstream is loaded and the chain-length check has passed.

Parameters:
- CHAIN_LEN, 1024, total configuration flip-flops from ccff_head to ccff_tail; must be ≥2.
- WORD_W, 8, bitstream word width.
- CNT_W, $clog2(CHAIN_LEN+2), derived; counter width, not to be overridden.

Ports:
- prog_clk  input  1  programming clock; the only clock.
- prog_reset_n  input  1  synchronous active-low reset.
- start  input  1  single-cycle pulse that begins a programming sequence.
- bs_data  input  WORD_W  bitstream word; LSB is shifted first.
- bs_valid  input  1  bs_data is valid.
- bs_ready  output  1  loader accepts a word this cycle.
- ccff_head  output  1  serial bit into the chain.
- ccff_shift_en  output  1  external clock-gate enable; the chain advances on the prog_clk edge where this is 1.
- ccff_tail  input  1  chain output; reflects all shifts completed before the current edge.
- IO_ISOL_N  output  1  0 = IOs isolated.
- busy  output  1  sequence in progress.
- done  output  1  programming completed successfully; held.
- error  output  1  chain-length mismatch; held.

Behaviour:
- Decided interface:
  - One clock, prog_clk.
  - Reset prog_reset_n is synchronous and active-low.
- All outputs are registered.
- Reset values:
  - bs_ready=0, ccff_head=0, ccff_shift_en=0, IO_ISOL_N=0, busy=0, done=0, error=0.
  - State IDLE; all counters 0.
- Reset asserted mid-sequence:
  - Same reset values on the next edge.
  - Chain content is undefined and IO_ISOL_N returns to 0.
- FSM states: IDLE, FLUSH, PROBE, LOAD, DONE, ERROR.
- IDLE, DONE and ERROR:
  - start moves to FLUSH and clears done and error.
  - start is ignored in every other state.
- FLUSH:
  - Drives ccff_head=0 and ccff_shift_en=1 for exactly CHAIN_LEN consecutive cycles, then goes to PROBE.
- PROBE:
  - Shift 1 carries ccff_head=1; every later shift carries 0. ccff_shift_en=1 every cycle.
  - cnt = shifts completed; ccff_tail is sampled each edge against that cnt.
  - tail=1 with cnt<CHAIN_LEN → ERROR (chain short).
  - tail=1 with cnt==CHAIN_LEN → LOAD.
  - cnt==CHAIN_LEN with tail=0 → ERROR (chain long or broken).
  - Shifting stops on the exit edge: no shift occurs in the cycle after the decision.
- LOAD:
  - A bit counter counts the CHAIN_LEN bits still to send.
  - bs_ready=1 only when the word buffer is empty and bits remain.
  - A word transfers on bs_valid && bs_ready.
  - After acceptance, the buffer shifts out LSB-first, one bit per cycle with ccff_shift_en=1.
  - Exactly one bubble cycle between words: ccff_shift_en=0, bs_ready=1.
  - When bs_valid=0, ccff_shift_en stays 0 and the chain holds.
  - Final word: only the remaining (CHAIN_LEN mod WORD_W, or WORD_W) low bits are shifted; upper bits are discarded.
  - The first bit sent ends in the tail-most flip-flop.
  - After the last bit's shift edge: ccff_shift_en=0, go to DONE.
- DONE: IO_ISOL_N=1, done=1, busy=0, bs_ready=0.
- ERROR: error=1, IO_ISOL_N=0, busy=0, no shifting, bs_ready=0.
- busy=1 in FLUSH, PROBE and LOAD.
- ccff_shift_en=0 in IDLE, DONE and ERROR.
- Minimum latency from start to done: 2·CHAIN_LEN + CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) + small constant cycles.

Test Plan:
- Nominal, CHAIN_LEN=16, WORD_W=8, 16-bit chain model: start, then words 0xA5, 0x3C always valid → 16 flush shifts, probe passes at cnt=16, chain holds A5/3C in LSB-first order (first bit at tail end), done=1, IO_ISOL_N=1, one bubble cycle between words.
- Chain model of 15 flops → error=1 at probe cnt=15, done=0, IO_ISOL_N=0, bs_ready never asserted.
- Chain model of 17 flops → error=1 at cnt=16, no LOAD entered; a subsequent start with the model fixed to 16 → done=1.
- CHAIN_LEN=20, WORD_W=8, words 0xFF, 0x00, 0xFF with random bs_valid gaps → exactly 20 shift_en pulses in LOAD; final 4 bits are 1; bs_ready=0 after third word.
- prog_reset_n low for 1 cycle mid-LOAD → all outputs at reset values next edge; a fresh start completes normally.
- start pulsed during FLUSH and during LOAD → ignored: no counter restart, shift count unchanged.
